// File: rtl/mem_port_pkg.sv
// rtl/mem_port_pkg.sv - shared constants, state encoding and abort value for mem_port.
package mem_port_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int CNT_WIDTH  = 8;

  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mem_port_watchdog.sv
// rtl/mem_port_watchdog.sv - saturating transaction watchdog; expired is high on the
// last allowed cycle so the abort lands on the edge ending cycle TIMEOUT.
module mem_port_watchdog
  import mem_port_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam bit                   ARMED = (TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CNT_WIDTH'(TIMEOUT - 1);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = ARMED && enable && (cnt_q >= LIMIT);

endmodule

// File: rtl/mem_port.sv
// rtl/mem_port.sv - converts controller read/write strobes into external req/ack transactions.
// Define MEM_PORT_POSTED_WRITE_EN to post writes through the one-entry address/data buffer.
module mem_port
  import mem_port_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  input  logic                  i_read_enable,
  input  logic                  i_write_enable,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic                  o_stall,
  output logic                  o_error,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_ack
);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic                  stall;
  logic                  wd_clear;
  logic                  wd_enable;
  logic                  wd_expired;

  mem_port_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    req_d     = req_q;
    we_d      = we_q;
    err_d     = err_q;
    stall     = 1'b0;
    wd_clear  = 1'b1;
    wd_enable = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_write_enable) begin
          // A write wins over a simultaneous read; the read is dropped and flagged.
          addr_d  = i_address;
          wdata_d = i_write_data;
          req_d   = 1'b1;
          we_d    = 1'b1;
          state_d = ST_WRITE;
          if (i_read_enable) begin
            err_d = 1'b1;
          end
`ifdef MEM_PORT_POSTED_WRITE_EN
          stall = i_read_enable & ~i_write_enable;
`else
          stall = 1'b1;
`endif
        end else if (i_read_enable) begin
          addr_d  = i_address;
          req_d   = 1'b1;
          we_d    = 1'b0;
          state_d = ST_READ;
          stall   = 1'b1;
        end
      end

      ST_READ, ST_WRITE: begin
        wd_clear  = 1'b0;
        wd_enable = 1'b1;
        stall     = 1'b1;
`ifdef MEM_PORT_POSTED_WRITE_EN
        if (state_q == ST_WRITE) begin
          stall = i_read_enable | i_write_enable;
        end
`endif
        // Ack takes priority over expiry in the same cycle.
        if (i_mem_ack || wd_expired) begin
          req_d   = 1'b0;
          state_d = ST_DONE;
          if (!i_mem_ack) begin
            err_d = 1'b1;
          end
          if (state_q == ST_READ) begin
            rdata_d = i_mem_ack ? i_mem_rdata : ALL_ONES;
          end
`ifdef MEM_PORT_POSTED_WRITE_EN
          if (state_q == ST_WRITE) begin
            state_d = ST_IDLE;
          end
`endif
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  assign o_read_data = rdata_q;
  assign o_stall     = stall;
  assign o_error     = err_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_req   = req_q;
  assign o_mem_we    = we_q;

endmodule

// File: doc/mem_port.md
# mem_port

Memory-side port sitting directly downstream of the CPU controller: converts the controller's single-cycle memory read/write strobes into a request/acknowledge transaction on the external memory bus. While a transaction is outstanding it stalls the controller, registers returned read data, and supervises each transaction with a timeout watchdog. Optionally, writes are posted through a one-entry buffer so the controller does not wait for write completion.

## Interface
- DATA_WIDTH, `DATA_WIDTH` (from define.v), width of data and address buses
- TIMEOUT, 64, cycles to wait for acknowledge before abort; 0 disables the watchdog; range 0..255
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous reset, active-high; name kept per codebase port naming
- i_address  input  DATA_WIDTH  controller memory address
- i_write_data  input  DATA_WIDTH  controller write data
- i_read_enable  input  1  controller read strobe, held high while o_stall is high
- i_write_enable  input  1  controller write strobe, held high while o_stall is high
- o_read_data  output  DATA_WIDTH  registered read data, held until the next read completes
- o_stall  output  1  freeze the controller (combinational)
- o_error  output  1  sticky: timeout or illegal simultaneous read+write
- o_mem_addr  output  DATA_WIDTH  registered external address
- o_mem_wdata  output  DATA_WIDTH  registered external write data
- o_mem_req  output  1  external request, held until acknowledge
- o_mem_we  output  1  1 = write, 0 = read; valid while o_mem_req is high
- i_mem_rdata  input  DATA_WIDTH  external read data, sampled on the i_mem_ack cycle
- i_mem_ack  input  1  single-cycle acknowledge; ignored when o_mem_req is low

## Operation
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE, read strobe high: latch the address; go to READ.
- IDLE, write strobe high: latch address and data; go to WRITE.
- IDLE, both strobes high: perform the write, drop the read, set o_error.
- READ/WRITE: o_mem_req=1. The watchdog counter clears on entry and increments each cycle.
- READ/WRITE with i_mem_ack: for a read, o_read_data <= i_mem_rdata. Go to DONE.
- Counter reaches TIMEOUT (TIMEOUT≠0) without ack: drop o_mem_req, set o_error. For a read, o_read_data <= all ones. Go to DONE.
- DONE: strobes ignored for one cycle, since the controller still holds the old strobe. Return to IDLE.
- o_stall = (IDLE and any strobe) or READ or WRITE.
- Counter width is 8 bits and saturates; it never wraps.
- o_error is cleared only by reset.

## Timing
- Reset values: state IDLE, o_read_data 0, o_mem_addr 0, o_mem_wdata 0, o_mem_req 0, o_mem_we 0, o_error 0, counter 0. o_stall follows its equation.
- Read with strobe in cycle 0 and ack in cycle k≥1:
  - o_mem_req high in cycles 1..k.
  - o_read_data valid from cycle k+1 (DONE), when o_stall is low.
- Zero-wait ack gives the minimum access period: 3 cycles per access.
- Timeout: if req rises in cycle 1, abort on the edge ending cycle TIMEOUT; o_error is high from cycle TIMEOUT+1.
- An ack arriving in the same cycle as the counter expiry counts as success, not timeout.
- Reset asserted mid-transaction: o_mem_req low after that edge; any later ack is ignored.

## Configuration
- MEM_PORT_POSTED_WRITE_EN defined:
  - A write in IDLE does not assert o_stall. Address and data go into the one-entry buffer; go to WRITE.
  - On ack or timeout, return directly to IDLE (no DONE).
  - While WRITE is busy, o_stall = any strobe. The strobe is serviced on the cycle after WRITE exits.
- Undefined: writes stall the controller exactly like reads, as in Operation.

## Structure
- FSM state encoding and the ALL_ONES read-abort value go in define.v with the other shared constants; DATA_WIDTH stays there.
- One sub-module: mem_port_watchdog, containing the counter, the TIMEOUT compare, and the saturate logic, with a clear/enable/expired interface.

## Test plan
- Read, addr 0x0010, ack after 3 cycles with rdata 0xBEEF -> o_stall high 4 cycles; o_read_data=0xBEEF in DONE; o_error=0.
- Write, addr 0x0020, data 0x1234, ack after 1 cycle -> o_mem_we=1, o_mem_wdata=0x1234.
  - Without the macro: stall for 2 cycles.
  - With the macro: stall never asserts.
- TIMEOUT=4, read, no ack -> req drops after 4 cycles; o_read_data=all ones; o_error stays 1.
- Read and write strobes together -> write performed, no read request, o_error=1.
- With MEM_PORT_POSTED_WRITE_EN: write then immediate read, write ack after 5 cycles -> read stalled until WRITE exits; read request starts the following cycle.
- Reset asserted in READ cycle 2 -> o_mem_req=0 the next cycle; state IDLE; a late ack leaves o_read_data=0.
